// File: rtl/dmem_bus_adapter.sv
// CPU data-memory stage to req/ack memory bridge; optional REQ timeout via DMEM_TIMEOUT_EN.
// Stall covers the IDLE launch cycle plus every REQ cycle; memory back-pressures via mem_ack.
module dmem_bus_adapter #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              stall,
  output logic              align_err,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state, state_nxt;

  logic access;
  logic misaligned;
  logic start;
  logic finish;
  logic timeout;
  logic unused_bits;

  assign access     = MemRead | MemWrite;
  assign misaligned = addr_in[1:0] != 2'b00;
  assign start      = (state == IDLE) && access && !misaligned;
  assign finish     = (state == REQ) && (mem_ack || timeout);

  assign unused_bits = ^{addr_in[31:ADDR_W+2], 32'(TIMEOUT_CYCLES)};

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] to_cnt;

  // An ack in the same cycle as expiry takes priority, so timeout excludes it.
  assign timeout = (state == REQ) && !mem_ack &&
                   (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt  <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= timeout;
      if (start)
        to_cnt <= '0;
      else if ((state == REQ) && !mem_ack && !timeout)
        to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    align_err = 1'b0;
    case (state)
      IDLE: begin
        stall     = access && !misaligned;
        align_err = access && misaligned;
      end
      REQ:     stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Request fields stay frozen through REQ; only mem_req and rd_data move on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data   <= '0;
    end else if (start) begin
      mem_req   <= 1'b1;
      mem_we    <= MemWrite;
      mem_addr  <= addr_in[ADDR_W+1:2];
      mem_wdata <= wr_data;
    end else if (finish) begin
      mem_req <= 1'b0;
      if (!mem_we)
        rd_data <= mem_ack ? mem_rdata : 32'hDEAD_BEEF;
    end
  end

endmodule

// File: tb/tb_dmem_bus_adapter.sv
// Directed bench for dmem_bus_adapter; exercises the timeout path when DMEM_TIMEOUT_EN is defined.
module tb_dmem_bus_adapter;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] addr_in, wr_data;
  logic [31:0] rd_data;
  logic        stall, align_err, bus_err;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int errs   = 0;
  int checks = 0;
  int scyc;

  logic [31:0] cap_addr, cap_we, cap_wdata;
  logic        berr_seen;

  always #5 clk = ~clk;

  dmem_bus_adapter #(.ADDR_W(16), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .addr_in(addr_in), .wr_data(wr_data),
    .rd_data(rd_data), .stall(stall), .align_err(align_err), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one access and counts stall cycles; ack lands on the n_ack-th REQ cycle (0 = never).
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input int n_ack,
                            input logic [31:0] rdat, output int sc);
    int   reqc;
    logic fin;
    reqc = 0; sc = 0; fin = 1'b0; berr_seen = 1'b0;
    MemRead = rd; MemWrite = wr; addr_in = a; wr_data = wd; mem_rdata = rdat;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (bus_err) berr_seen = 1'b1;
      if (!stall) begin
        fin = 1'b1;
        break;
      end
      sc++;
      if (mem_req) begin
        if (reqc == 0) begin
          cap_addr  = 32'(mem_addr);
          cap_we    = 32'(mem_we);
          cap_wdata = mem_wdata;
        end
        reqc++;
        mem_ack = (reqc == n_ack);
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
    end
    chk("access_completes", 32'(fin), 32'd1);
  endtask

  task automatic idle_inputs();
    MemRead = 1'b0; MemWrite = 1'b0; addr_in = '0; wr_data = '0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    chk("rst_rd_data",   rd_data,        32'd0);
    chk("rst_stall",     32'(stall),     32'd0);
    chk("rst_align_err", 32'(align_err), 32'd0);
    chk("rst_bus_err",   32'(bus_err),   32'd0);
    reset = 1'b1;
    step();

    // load, ack on second REQ cycle
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2, 32'h1234_5678, scyc);
    chk("ld_stall_cycles", 32'(scyc), 32'd3);
    chk("ld_mem_addr", cap_addr, 32'd4);
    chk("ld_mem_we",   cap_we,   32'd0);
    chk("ld_rd_data",  rd_data,  32'h1234_5678);
    chk("ld_done_req", 32'(mem_req), 32'd0);
    idle_inputs();
    step();
    chk("ld_idle_stall", 32'(stall), 32'd0);

    // store with immediate ack
    run_access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1, 32'hAAAA_5555, scyc);
    chk("st_stall_cycles", 32'(scyc), 32'd2);
    chk("st_mem_we",    cap_we,    32'd1);
    chk("st_mem_wdata", cap_wdata, 32'hCAFE_F00D);
    chk("st_mem_addr",  cap_addr,  32'd8);
    chk("st_rd_keep",   rd_data,   32'h1234_5678);
    idle_inputs();
    step();

    // misaligned load
    MemRead = 1'b1; addr_in = 32'h0000_0013;
    #1;
    chk("mis_align_err", 32'(align_err), 32'd1);
    chk("mis_stall",     32'(stall),     32'd0);
    step();
    chk("mis_no_req", 32'(mem_req), 32'd0);
    idle_inputs();
    #1;
    chk("mis_err_clear", 32'(align_err), 32'd0);
    chk("mis_stall2",    32'(stall),     32'd0);
    chk("mis_rd_keep",   rd_data,        32'h1234_5678);
    step();

    // read and write together -> write
    run_access(1'b1, 1'b1, 32'h0000_0004, 32'h0BAD_F00D, 1, 32'h1111_1111, scyc);
    chk("both_mem_we",   cap_we,   32'd1);
    chk("both_mem_addr", cap_addr, 32'd1);
    chk("both_rd_keep",  rd_data,  32'h1234_5678);
    idle_inputs();
    step();

    // stray ack in IDLE
    mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    step();
    mem_ack = 1'b0;
    #1;
    chk("idle_ack_rd",  rd_data,        32'h1234_5678);
    chk("idle_ack_req", 32'(mem_req),   32'd0);
    step();

`ifdef DMEM_TIMEOUT_EN
    run_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h0F0F_0F0F, scyc);
    chk("to_stall_cycles", 32'(scyc), 32'd5);
    chk("to_bus_err",      32'(berr_seen), 32'd1);
    chk("to_rd_data",      rd_data, 32'hDEAD_BEEF);
    idle_inputs();
    step();
    chk("to_bus_err_clear", 32'(bus_err), 32'd0);
    run_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4, 32'h7777_7777, scyc);
    chk("ackwin_stall_cycles", 32'(scyc), 32'd5);
    chk("ackwin_bus_err",      32'(berr_seen), 32'd0);
    chk("ackwin_rd_data",      rd_data, 32'h7777_7777);
    idle_inputs();
    step();
`else
    run_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 20, 32'h0F0F_0F0F, scyc);
    chk("long_stall_cycles", 32'(scyc), 32'd21);
    chk("long_bus_err",      32'(berr_seen), 32'd0);
    chk("long_rd_data",      rd_data, 32'h0F0F_0F0F);
    idle_inputs();
    step();
`endif

    // reset mid-REQ, late ack ignored
    MemRead = 1'b1; addr_in = 32'h0000_0040;
    step();
    #1;
    chk("rr_req_up", 32'(mem_req), 32'd1);
    #1;
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("rr_req_drop", 32'(mem_req), 32'd0);
    chk("rr_stall",    32'(stall),   32'd0);
    #2;
    reset = 1'b1;
    step();
    step();
    mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
    step();
    mem_ack = 1'b0;
    #1;
    chk("rr_late_req",   32'(mem_req), 32'd0);
    chk("rr_late_stall", 32'(stall),   32'd0);
    chk("rr_late_rd",    rd_data,      32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dmem_bus_adapter.md
Name: dmem_bus_adapter

Overview:
Sits directly downstream of the CPU's memory stage. It converts the single-cycle data-memory request (MemRead/MemWrite, ALU address, store data) into a req/ack handshake toward an external word-addressed data memory with variable wait states. While a transaction is outstanding it asserts stall so the CPU freezes the PC and register writeback. Load data is returned to WriteBack on the release cycle.

Parameters:
ADDR_W, 16, word-address width driven on mem_addr; mem_addr = addr_in[ADDR_W+1:2]
TIMEOUT_CYCLES, 64, cycles spent in REQ before abort; used only when the optional feature is compiled in

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
MemRead  input  1  load request from CPU control
MemWrite  input  1  store request from CPU control
addr_in  input  32  byte address (ALU result)
wr_data  input  32  store data (rt register value)
rd_data  output  32  load data to WriteBack
stall  output  1  1 = CPU must hold PC and suppress RegWrite this cycle
align_err  output  1  one-cycle flag: misaligned access rejected
bus_err  output  1  one-cycle flag: transaction timed out (optional feature)
mem_req  output  1  request to external memory
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  word address
mem_wdata  output  32  write data
mem_ack  input  1  one-cycle completion pulse from memory
mem_rdata  input  32  read data, valid while mem_ack = 1

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE; mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rd_data = 0, bus_err = 0, timeout counter = 0. stall and align_err are combinational and read 0 in IDLE with no access.
- access = MemRead | MemWrite. If both are set, the access is a write.
- misaligned = addr_in[1:0] != 2'b00.
- State machine with states IDLE, REQ and DONE.
- IDLE, access and aligned:
  - stall = 1 combinationally in the same cycle.
  - On the clock edge, register mem_addr, mem_wdata and mem_we, set mem_req = 1, and go to REQ.
- IDLE, access and misaligned:
  - No transaction is started; stall = 0.
  - align_err = 1 combinationally for that cycle; rd_data is unchanged; the state stays IDLE.
- IDLE, no access: stall = 0; no change.
- REQ:
  - stall = 1.
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until ack.
  - On a cycle with mem_ack = 1: clear mem_req at that edge, load rd_data <= mem_rdata if this is a read (rd_data keeps its old value on a write), and go to DONE.
- DONE: stall = 0 for exactly one cycle so the CPU retires the instruction; access inputs are ignored; go to IDLE.
- Latency: with an ack N cycles after mem_req rises (N ≥ 1 counted from the REQ entry edge), stall is high for N+1 cycles.
- mem_ack while in IDLE or DONE is ignored.
- Back-to-back accesses: the next access is first seen in IDLE, one cycle after DONE.
- Reset asserted mid-REQ: mem_req drops immediately (asynchronously) and the block returns to IDLE; an ack arriving afterwards is ignored.
- rd_data holds its value between loads.

Optional Feature:
Macro: DMEM_TIMEOUT_EN.
- Defined:
  - A counter clears on REQ entry and increments on each REQ cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES−1 with no ack: drop mem_req, set rd_data = 32'hDEADBEEF if this is a read, pulse bus_err = 1 for one cycle (registered, coincident with DONE), and go to DONE.
  - An ack in the same cycle as the timeout wins: normal completion, no bus_err.
- Undefined: no counter; REQ waits indefinitely; bus_err is tied to 0.

Test Plan:
- Load at addr_in = 0x0000_0010, mem_ack two cycles after mem_req rises, mem_rdata = 0x1234_5678:
  - mem_addr = 4 and mem_we = 0.
  - stall is high for 3 cycles, then DONE with rd_data = 0x1234_5678.
- Store at 0x0000_0020 with wr_data = 0xCAFE_F00D and an immediate ack:
  - mem_we = 1, mem_wdata = 0xCAFE_F00D, mem_addr = 8.
  - stall is high for 2 cycles.
  - rd_data keeps the previous load value.
- Load at 0x0000_0013 (misaligned):
  - align_err = 1 for 1 cycle.
  - stall = 0, mem_req never rises, state stays IDLE.
- MemRead = MemWrite = 1 at 0x4: a write transaction is issued (mem_we = 1).
- reset = 0 pulsed while in REQ, then an ack 2 cycles later:
  - mem_req = 0 immediately and stall = 0.
  - The late ack is ignored; the state stays IDLE.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, a load with no ack:
  - After 4 REQ cycles: bus_err pulses once and rd_data = 0xDEADBEEF.
  - stall then releases via DONE.
